// File: rtl/datatape_pkg.sv
// Shared framer definitions: state encoding and fixed line symbols.
package datatape_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE0,
        ST_PRE1,
        ST_SYNC,
        ST_SEQ,
        ST_LEN,
        ST_PAYLOAD,
        ST_CSUM
    } state_t;

    localparam logic [7:0] PREAMBLE            = 8'hAA;
    localparam logic [7:0] SYNC                = 8'h7E;
    localparam logic [7:0] IDLE_SYMBOL_DEFAULT = 8'h80;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock byte FIFO, first-word-fall-through: the head byte is always visible on o_rdData.
module sync_fifo #(
    parameter int DEPTH = 64
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_wrEn,
    input  logic [7:0]               i_wrData,
    input  logic                     i_rdEn,
    output logic [7:0]               o_rdData,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [LW-1:0] r_level;
    logic          w_wr;
    logic          w_rd;

    // A write while full is refused even if a pop happens in the same cycle.
    assign o_full   = (r_level == LW'(DEPTH));
    assign w_wr     = i_wrEn & ~o_full;
    assign w_rd     = i_rdEn & (r_level != '0);
    assign o_rdData = r_mem[r_rdPtr];
    assign o_level  = r_level;

    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wrPtr] <= i_wrData;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else begin
            if (w_wr) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_rd) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            if (w_wr && !w_rd) begin
                r_level <= r_level + LW'(1);
            end else if (!w_wr && w_rd) begin
                r_level <= r_level - LW'(1);
            end
        end
    end

endmodule

// File: rtl/line_framer.sv
// Packs buffered payload bytes into AA AA 7E SEQ LEN payload CSUM frames for the video output stage.
module line_framer
    import datatape_pkg::*;
#(
    parameter int          FIFO_DEPTH  = 64,
    parameter int          PAYLOAD_MAX = 32,
    parameter logic [7:0]  IDLE_SYMBOL = IDLE_SYMBOL_DEFAULT
) (
    input  logic                          output_px_clk,
    input  logic                          framer_rst,
    input  logic [7:0]                    byte_in,
    input  logic                          byte_valid,
    output logic                          byte_ready,
    input  logic                          output_ready,
    output logic [7:0]                    data_out,
    output logic                          data_out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          byte_drop
);

    localparam int            LW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LW-1:0] MAX_LEVEL = LW'(PAYLOAD_MAX);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_seq;
    logic [7:0] r_len;
    logic [7:0] r_cnt;
    logic [7:0] r_sum;
    logic       r_drop;
    logic [7:0] w_head;
    logic       w_full;
    logic       w_xfer;
    logic       w_pop;
    logic       w_enterPre0;
    logic [7:0] w_lenSnap;

    sync_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .i_clk    (output_px_clk),
        .i_rst    (framer_rst),
        .i_wrEn   (byte_valid),
        .i_wrData (byte_in),
        .i_rdEn   (w_pop),
        .o_rdData (w_head),
        .o_level  (fifo_level),
        .o_full   (w_full)
    );

    assign byte_ready     = ~w_full;
    assign byte_drop      = r_drop;
    assign data_out_ready = (r_state != ST_IDLE);
    assign w_xfer         = data_out_ready & output_ready;
    assign w_pop          = (r_state == ST_PAYLOAD) & w_xfer;
    assign w_lenSnap      = 8'((fifo_level > MAX_LEVEL) ? MAX_LEVEL : fifo_level);
    assign w_enterPre0    = ((r_state == ST_IDLE) & output_ready) |
                            ((r_state == ST_CSUM) & w_xfer);

    always_comb begin
        w_next   = r_state;
        data_out = IDLE_SYMBOL;
        case (r_state)
            ST_IDLE: begin
                if (output_ready) w_next = ST_PRE0;
            end
            ST_PRE0: begin
                data_out = PREAMBLE;
                if (w_xfer) w_next = ST_PRE1;
            end
            ST_PRE1: begin
                data_out = PREAMBLE;
                if (w_xfer) w_next = ST_SYNC;
            end
            ST_SYNC: begin
                data_out = SYNC;
                if (w_xfer) w_next = ST_SEQ;
            end
            ST_SEQ: begin
                data_out = r_seq;
                if (w_xfer) w_next = ST_LEN;
            end
            ST_LEN: begin
                data_out = r_len;
                if (w_xfer) w_next = (r_len == 8'd0) ? ST_CSUM : ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                data_out = w_head;
                if (w_xfer && r_cnt == 8'd1) w_next = ST_CSUM;
            end
            ST_CSUM: begin
                data_out = ~r_sum + 8'd1;
                if (w_xfer) w_next = ST_PRE0;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // The checksum accumulates every transferred byte from SEQ onward, so CSUM is its two's complement.
    always_ff @(posedge output_px_clk) begin
        if (framer_rst) begin
            r_state <= ST_IDLE;
            r_seq   <= 8'd0;
            r_len   <= 8'd0;
            r_cnt   <= 8'd0;
            r_sum   <= 8'd0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (byte_valid && !byte_ready) begin
                r_drop <= 1'b1;
            end
            if (w_enterPre0) begin
                r_len <= w_lenSnap;
                r_sum <= 8'd0;
            end
            if (w_xfer) begin
                case (r_state)
                    ST_SEQ: begin
                        r_sum <= r_sum + r_seq;
                    end
                    ST_LEN: begin
                        r_sum <= r_sum + r_len;
                        r_cnt <= r_len;
                    end
                    ST_PAYLOAD: begin
                        r_sum <= r_sum + w_head;
                        r_cnt <= r_cnt - 8'd1;
                    end
                    ST_CSUM: begin
                        r_seq <= r_seq + 8'd1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_line_framer.sv
// Self-checking bench for line_framer: directed frame scenarios plus randomized traffic against a packet-level model.
module tb_line_framer;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] byteIn;
   logic       byteValid;
   logic       byteReady;
   logic       outputReady;
   logic [7:0] dataOut;
   logic       dataOutReady;
   logic [6:0] fifoLevel;
   logic       byteDrop;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   line_framer dut (
      .output_px_clk  (clk),
      .framer_rst     (rst),
      .byte_in        (byteIn),
      .byte_valid     (byteValid),
      .byte_ready     (byteReady),
      .output_ready   (outputReady),
      .data_out       (dataOut),
      .data_out_ready (dataOutReady),
      .fifo_level     (fifoLevel),
      .byte_drop      (byteDrop)
   );

   // Reference model: a byte queue for the buffer and a queue of the symbols still owed in the current frame.
   logic [7:0] modelQ[$];
   logic [7:0] pkt[$];
   bit         pktPay[$];
   bit         inPkt;
   logic [7:0] modelSeq;
   bit         modelDrop;
   logic [7:0] logQ[$];

   // A frame is fixed at the moment it starts: its length is whatever is buffered then, capped at 32.
   function automatic void buildPacket();
      int len;
      int sum;
      len = (modelQ.size() > 32) ? 32 : modelQ.size();
      sum = int'(modelSeq) + len;
      pkt.delete();
      pktPay.delete();
      pkt.push_back(8'hAA); pktPay.push_back(1'b0);
      pkt.push_back(8'hAA); pktPay.push_back(1'b0);
      pkt.push_back(8'h7E); pktPay.push_back(1'b0);
      pkt.push_back(modelSeq); pktPay.push_back(1'b0);
      pkt.push_back(8'(len)); pktPay.push_back(1'b0);
      for (int i = 0; i < len; i++) begin
         pkt.push_back(modelQ[i]);
         pktPay.push_back(1'b1);
         sum += int'(modelQ[i]);
      end
      pkt.push_back(8'((256 - (sum % 256)) % 256));
      pktPay.push_back(1'b0);
      inPkt = 1'b1;
   endfunction

   // Model advances on the same edge as the design, using the inputs held across that edge.
   always @(posedge clk) begin
      int pre;
      if (rst) begin
         modelQ.delete();
         pkt.delete();
         pktPay.delete();
         inPkt     = 1'b0;
         modelSeq  = 8'd0;
         modelDrop = 1'b0;
      end else begin
         pre = modelQ.size();
         if (byteValid && pre >= 64) modelDrop = 1'b1;
         if (!inPkt) begin
            if (outputReady) buildPacket();
         end else if (outputReady) begin
            if (pktPay[0]) void'(modelQ.pop_front());
            void'(pkt.pop_front());
            void'(pktPay.pop_front());
            if (pkt.size() == 0) begin
               modelSeq = modelSeq + 8'd1;
               buildPacket();
            end
         end
         if (byteValid && pre < 64) modelQ.push_back(byteIn);
      end
   end

   // Every symbol accepted by the output stage is recorded for frame-level checks.
   always @(negedge clk) begin
      if (!rst && dataOutReady && outputReady) logQ.push_back(dataOut);
   end

   task automatic checkOutput(input string tag, input int observed, input int expected);
      total++;
      if (observed != expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Drives one cycle of inputs, then compares every output against the model just after the edge.
   task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r, input logic rs);
      byteValid   = v;
      byteIn      = d;
      outputReady = r;
      rst         = rs;
      @(posedge clk);
      #1;
      checkOutput("valid", dataOutReady, inPkt);
      checkOutput("data", dataOut, inPkt ? pkt[0] : 8'h80);
      checkOutput("level", fifoLevel, modelQ.size());
      checkOutput("ready", byteReady, (modelQ.size() < 64) ? 1 : 0);
      checkOutput("drop", byteDrop, modelDrop);
   endtask

   task automatic resetDut();
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      logQ.delete();
   endtask

   task automatic waitLog(input int n);
      int budget = 0;
      while (logQ.size() < n && budget < 500) begin
         applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
         budget++;
      end
      checkOutput("logTimeout", (logQ.size() >= n) ? 1 : 0, 1);
   endtask

   task automatic checkSeq(input string tag, input int base, input logic [7:0] exp[$]);
      for (int i = 0; i < exp.size(); i++) begin
         checkOutput(tag, (base + i < logQ.size()) ? int'(logQ[base + i]) : -1, exp[i]);
      end
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [7:0] expQ[$];
      logic [7:0] held;
      int readyPct;

      byteValid = 1'b0; byteIn = 8'h00; outputReady = 1'b0; rst = 1'b1;

      resetDut();
      checkOutput("rstLevel", fifoLevel, 0);
      checkOutput("rstData", dataOut, 8'h80);
      checkOutput("rstReady", byteReady, 1);

      // Empty buffer: header-only frame.
      resetDut();
      waitLog(6);
      expQ = '{8'hAA, 8'hAA, 8'h7E, 8'h00, 8'h00, 8'h00};
      checkSeq("emptyFrame", 0, expQ);
      checkOutput("emptyLevel", fifoLevel, 0);

      // Three bytes then a continuous stream.
      resetDut();
      applyStimulus(1'b1, 8'h01, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h02, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h03, 1'b0, 1'b0);
      waitLog(15);
      expQ = '{8'hAA, 8'hAA, 8'h7E, 8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 8'hF7,
               8'hAA, 8'hAA, 8'h7E, 8'h01, 8'h00, 8'hFF};
      checkSeq("threeBytes", 0, expQ);

      // Forty bytes split into a full frame and a remainder frame.
      resetDut();
      for (int i = 0; i < 40; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
      waitLog(52);
      checkOutput("split1Seq", logQ[3], 8'h00);
      checkOutput("split1Len", logQ[4], 8'h20);
      for (int i = 0; i < 32; i++) checkOutput("split1Pay", logQ[5 + i], i);
      checkOutput("split2Seq", logQ[41], 8'h01);
      checkOutput("split2Len", logQ[42], 8'h08);
      for (int i = 0; i < 8; i++) checkOutput("split2Pay", logQ[43 + i], 8'h20 + i);

      // Stall in the middle of the payload.
      resetDut();
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
      waitLog(8);
      held = dataOut;
      checkOutput("stallStart", held, 8'hC3);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
         checkOutput("stallData", dataOut, 8'hC3);
         checkOutput("stallValid", dataOutReady, 1);
      end
      waitLog(16);
      for (int i = 0; i < 10; i++) checkOutput("stallPay", logQ[5 + i], 8'hC0 + i);

      // Overfill: the 65th byte is refused and flagged.
      resetDut();
      for (int i = 0; i < 65; i++) applyStimulus(1'b1, 8'(i + 1), 1'b0, 1'b0);
      checkOutput("fullLevel", fifoLevel, 64);
      checkOutput("fullReady", byteReady, 0);
      checkOutput("fullDrop", byteDrop, 1);
      waitLog(82);
      checkOutput("fullLen1", logQ[4], 8'h20);
      checkOutput("fullLen2", logQ[42], 8'h20);
      checkOutput("fullLast", logQ[74], 8'h40);
      checkOutput("fullLen3", logQ[80], 8'h00);

      // Reset in the middle of a payload abandons the frame.
      resetDut();
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, 8'h50 + 8'(i), 1'b0, 1'b0);
      waitLog(8);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
      checkOutput("midRstData", dataOut, 8'h80);
      checkOutput("midRstLevel", fifoLevel, 0);
      checkOutput("midRstValid", dataOutReady, 0);
      logQ.delete();
      waitLog(6);
      checkOutput("midRstSeq", logQ[3], 8'h00);
      checkOutput("midRstLen", logQ[4], 8'h00);

      // Randomized traffic with varying output pressure and occasional resets.
      resetDut();
      for (int phase = 0; phase < 6; phase++) begin
         readyPct = (phase % 3 == 0) ? 10 : ((phase % 3 == 1) ? 60 : 95);
         for (int c = 0; c < 500; c++) begin
            applyStimulus(($urandom_range(0, 99) < 55) ? 1'b1 : 1'b0,
                          8'($urandom()),
                          ($urandom_range(0, 99) < readyPct) ? 1'b1 : 1'b0,
                          ($urandom_range(0, 599) == 0) ? 1'b1 : 1'b0);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
